alu_issue_stage: RTL and testbench

//  Upstream issue stage for the combinational 20-bit ALU. It accepts {sel,a,b} operations on a

---
 rtl/alu_issue_stage.sv | 120 ++++++++++++
 tb/tb_alu_issue_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU: a small op FIFO drives the ALU
// from its head, and the flagged ALU result is held in a valid/ready output slot.
module alu_issue_stage #(
    parameter int W     = 20,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_sel,
    input  logic [W-1:0]     alu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_c,
    output logic             out_zero,
    output logic             out_div0,
    output logic [CNT_W-1:0] op_count
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
    localparam logic [2:0]    OP_NOP = 3'b000;
    localparam logic [2:0]    OP_DIV = 3'b100;

    logic [W-1:0]     a_mem_p0   [DEPTH];
    logic [W-1:0]     b_mem_p0   [DEPTH];
    logic [2:0]       sel_mem_p0 [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             empty;
    logic             push;
    logic             pop;
    logic             capture;
    logic             vld_p1;
    logic [W-1:0]     c_p1;
    logic             zero_p1;
    logic             div0_p1;
    logic [CNT_W-1:0] op_count_q;

    function automatic logic is_div0(input logic [2:0] sel, input logic [W-1:0] b);
        return (sel == OP_DIV) && (b == '0);
    endfunction

    // A zero divisor saturates the result to all ones; the ALU's value is discarded.
    function automatic logic [W-1:0] sat_result(input logic [2:0] sel, input logic [W-1:0] b,
                                                input logic [W-1:0] c);
        return is_div0(sel, b) ? '1 : c;
    endfunction

    assign empty    = (count == '0);
    assign in_ready = (count != FULL);
    assign push     = in_valid & in_ready;
    assign pop      = !empty & (!vld_p1 | out_ready);
    assign capture  = pop & (alu_sel != OP_NOP);

    assign alu_a   = empty ? '0 : a_mem_p0[rd_ptr];
    assign alu_b   = empty ? '0 : b_mem_p0[rd_ptr];
    assign alu_sel = empty ? OP_NOP : sel_mem_p0[rd_ptr];

    assign out_valid = vld_p1;
    assign out_c     = c_p1;
    assign out_zero  = zero_p1;
    assign out_div0  = div0_p1;
    assign op_count  = op_count_q;

    // p0: FIFO storage (ALU operands are taken from the head of this stage)
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem_p0[wr_ptr]   <= in_a;
            b_mem_p0[wr_ptr]   <= in_b;
            sel_mem_p0[wr_ptr] <= in_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // p1: registered ALU result slot toward write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            c_p1       <= '0;
            zero_p1    <= 1'b0;
            div0_p1    <= 1'b0;
            op_count_q <= '0;
        end else begin
            if (capture) begin
                vld_p1  <= 1'b1;
                c_p1    <= sat_result(alu_sel, alu_b, alu_c);
                zero_p1 <= !is_div0(alu_sel, alu_b) && (alu_c == '0);
                div0_p1 <= is_div0(alu_sel, alu_b);
            end else if (vld_p1 && out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (vld_p1 && out_ready) op_count_q <= op_count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized ops, with a queue
// scoreboard fed at acceptance and drained by an independent output monitor.
module tb_alu_issue_stage;

    localparam int W     = 20;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam longint MOD = 64'd1 << W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_sel = 3'b000;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [2:0]       alu_sel;
    logic [W-1:0]     alu_c;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_c;
    logic             out_zero;
    logic             out_div0;
    logic [CNT_W-1:0] op_count;

    typedef struct packed {
        logic [W-1:0] c;
        logic         zero;
        logic         div0;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   model_cnt = 0;
    logic done = 1'b0;

    alu_issue_stage #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
        .out_zero(out_zero), .out_div0(out_div0), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // The ALU itself; a zero divisor yields a junk value the stage must ignore.
    always_comb begin
        alu_c = '0;
        case (alu_sel)
            3'b001:  alu_c = alu_a + alu_b;
            3'b010:  alu_c = alu_a - alu_b;
            3'b011:  alu_c = alu_a * alu_b;
            3'b100:  alu_c = (alu_b == '0) ? 20'h5A5A5 : alu_a / alu_b;
            3'b101:  alu_c = alu_a & alu_b;
            3'b110:  alu_c = alu_a | alu_b;
            3'b111:  alu_c = alu_a ^ alu_b;
            default: alu_c = 20'h3C3C3;
        endcase
    end

    function automatic exp_t model(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint r  = 0;
        exp_t   e;
        e.div0 = 1'b0;
        case (sel)
            3'd1: r = (ua + ub) % MOD;
            3'd2: r = (ua - ub + MOD) % MOD;
            3'd3: r = (ua * ub) % MOD;
            3'd4: if (ub == 0) begin e.div0 = 1'b1; r = MOD - 1; end else r = ua / ub;
            3'd5: r = ua & ub;
            3'd6: r = ua | ub;
            3'd7: r = ua ^ ub;
            default: r = 0;
        endcase
        e.c    = W'(r);
        e.zero = !e.div0 && (r == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Acceptance side: every accepted non-NOP op owes exactly one result.
    initial forever begin
        @(negedge clk);
        if (!rst && in_valid && in_ready && in_sel != 3'b000)
            sb.push_back(model(in_sel, in_a, in_b));
    end

    // Output monitor: ordering, values, hold stability and delivered-op count.
    initial begin
        logic         hold_q = 1'b0;
        logic [W+1:0] held_q = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                model_cnt = 0;
                hold_q    = 1'b0;
            end else begin
                chk("op_count", 64'(op_count), 64'(model_cnt % (1 << CNT_W)));
                if (hold_q)
                    chk("hold_stable", 64'({out_valid, out_c, out_zero, out_div0}), 64'({1'b1, held_q}));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_result: got 0x%0h expected no result at %0t", out_c, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("result", 64'({out_c, out_zero, out_div0}), 64'({e.c, e.zero, e.div0}));
                    end
                    model_cnt++;
                end
                hold_q = out_valid && !out_ready;
                held_q = {out_c, out_zero, out_div0};
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_sel   = s;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                next_drive();
                in_valid = 1'b0;
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: got in_ready=0 expected acceptance at %0t", $time);
        in_valid = 1'b0;
    endtask

    task automatic send_expect(input string name, input logic [2:0] s, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] c, input logic z, input logic d);
        send(s, a, b);
        @(negedge clk);
        @(negedge clk);
        chk({name, "_valid"}, 64'(out_valid), 64'(1));
        chk({name, "_c"}, 64'(out_c), 64'(c));
        chk({name, "_flags"}, 64'({out_zero, out_div0}), 64'({z, d}));
        next_drive();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        next_drive();
        next_drive();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_c", 64'({out_c, out_zero, out_div0}), 64'(0));
        chk("rst_alu_sel", 64'(alu_sel), 64'(0));
        chk("rst_op_count", 64'(op_count), 64'(0));
        next_drive();

        // add 5+7: head visible one cycle after acceptance, result one cycle later
        out_ready = 1'b1;
        send(3'b001, 20'd5, 20'd7);
        @(negedge clk);
        chk("lat_alu_sel", 64'(alu_sel), 64'(1));
        chk("lat_alu_ab", 64'({alu_a, alu_b}), 64'({20'd5, 20'd7}));
        @(negedge clk);
        chk("lat_out_valid", 64'(out_valid), 64'(1));
        chk("add_c", 64'({out_c, out_zero}), 64'({20'd12, 1'b0}));
        @(negedge clk);
        chk("add_op_count", 64'(op_count), 64'(1));
        next_drive();

        send_expect("sub_eq", 3'b010, 20'd9, 20'd9, 20'd0, 1'b1, 1'b0);
        send_expect("sub_wrap", 3'b010, 20'd0, 20'd1, 20'hFFFFF, 1'b0, 1'b0);
        send_expect("div0", 3'b100, 20'd100, 20'd0, 20'hFFFFF, 1'b0, 1'b1);
        send_expect("div", 3'b100, 20'd100, 20'd7, 20'd14, 1'b0, 1'b0);
        send_expect("mul_trunc", 3'b011, 20'hFFFFF, 20'd3, 20'hFFFFD, 1'b0, 1'b0);

        // Backpressure: 4 in the FIFO plus 1 in the slot, then the sixth waits
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(3'b001, W'(i * 3 + 1), W'(i));
        in_valid = 1'b1;
        in_sel   = 3'b111;
        in_a     = 20'hABCDE;
        in_b     = 20'h12345;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_in_ready", 64'(in_ready), 64'(0));
            chk("full_out_valid", 64'(out_valid), 64'(1));
        end
        next_drive();
        out_ready = 1'b1;
        fork
            send(3'b111, 20'hABCDE, 20'h12345);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("drain_stream", 64'(out_valid), 64'(1));
            end
        join
        next_drive();
        @(negedge clk);
        chk("drain_empty", 64'(sb.size()), 64'(0));
        next_drive();

        // NOP in the middle produces no result
        do_reset();
        send(3'b001, 20'd1, 20'd1);
        send(3'b000, 20'd4, 20'd4);
        send(3'b111, 20'hF0, 20'h0F);
        repeat (4) @(negedge clk);
        chk("nop_op_count", 64'(op_count), 64'(2));
        chk("nop_sb_empty", 64'(sb.size()), 64'(0));
        next_drive();

        // Reset with a held result and three ops buffered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'b110, W'(i + 8), W'(i));
        @(negedge clk);
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        next_drive();
        rst = 1'b1;
        next_drive();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_alu_sel", 64'(alu_sel), 64'(0));
        chk("mid_rst_op_count", 64'(op_count), 64'(0));
        repeat (3) @(negedge clk);
        next_drive();

        // Randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [2:0]   s;
                    logic [W-1:0] a;
                    logic [W-1:0] b;
                    s = 3'($urandom_range(0, 7));
                    a = W'($urandom);
                    case ($urandom_range(0, 3))
                        0:       b = '0;
                        1:       b = a;
                        2:       b = W'($urandom_range(1, 15));
                        default: b = W'($urandom);
                    endcase
                    send(s, a, b);
                    if ($urandom_range(0, 3) == 0) next_drive();
                end
                done = 1'b1;
            end
            while (!done) begin
                next_drive();
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("final_drain", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
